cpu_mul_seq: RTL

Multi-cycle multiply sequencer for the CPU execute stage. It time-shares one external 16x16 unsigned multiplier cell with a registered product output, instead of instantiating one cell per partial product. It issues the required partial products in sequence, accumulates them with the correct shifts, and returns either the low or the high 32 bits of the 64-bit unsigned product. A start/ready/done handshake connects it to the pipeline stall logic.

---
 rtl/cpu_mul_seq_if.sv | 24 ++
 rtl/cpu_mul_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cpu_mul_seq_if.sv
// Pipeline-side request/response bus of the multi-cycle multiply sequencer.
// The master is the execute-stage control; the slave is cpu_mul_seq.
interface cpu_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_hi;
    logic             abort;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op_hi, abort, src1, src2,
        input  ready, done, result
    );

    modport slave (
        input  start, op_hi, abort, src1, src2,
        output ready, done, result
    );
endinterface

// File: rtl/cpu_mul_seq.sv
// Multiply sequencer: time-shares one registered 16x16 multiplier cell, issuing
// 3 (low word) or 4 (high word) partial products and accumulating them into 64 bits.
module cpu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_mul_seq_if.slave         bus,
    output logic [WIDTH/2-1:0]   mul_a,
    output logic [WIDTH/2-1:0]   mul_b,
    output logic                 mul_en,
    input  logic [WIDTH-1:0]     mul_p
);
    localparam int HALF  = WIDTH / 2;
    localparam int ACC_W = 2 * WIDTH;
    localparam int SH_W  = $clog2(ACC_W);
    localparam logic [SH_W-1:0] SH_MID = SH_W'(HALF);
    localparam logic [SH_W-1:0] SH_TOP = SH_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [1:0]       k;
    logic [1:0]       last_k;
    logic [1:0]       next_k;
    logic             op_hi_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic             prod_v;
    logic [1:0]       prod_k;
    logic [SH_W-1:0]  shamt;

    function automatic logic [HALF-1:0] pick(input logic [WIDTH-1:0] w, input logic upper);
        return upper ? w[WIDTH-1:HALF] : w[HALF-1:0];
    endfunction

    // Issue order aL*bL, aL*bH, aH*bL, aH*bH: k[1] selects the A half, k[0] the B half.
    assign next_k = k + 2'd1;

    always_comb begin
        shamt = '0;
        unique case (prod_k)
            2'd0:    shamt = '0;
            2'd1,
            2'd2:    shamt = SH_MID;
            default: shamt = SH_TOP;
        endcase
        acc_sum = acc + ({{WIDTH{1'b0}}, mul_p} << shamt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            k          <= '0;
            last_k     <= '0;
            op_hi_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            prod_v     <= 1'b0;
            prod_k     <= '0;
            mul_en     <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            bus.ready  <= 1'b1;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else begin
            // NOTE: defaults first; a later non-blocking assignment in the case below overrides them.
            bus.done <= 1'b0;
            prod_v   <= mul_en;
            prod_k   <= k;
            if (prod_v) begin
                acc <= acc_sum;
            end

            unique case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        a_q       <= bus.src1;
                        b_q       <= bus.src2;
                        op_hi_q   <= bus.op_hi;
                        acc       <= '0;
                        k         <= 2'd0;
                        last_k    <= bus.op_hi ? 2'd3 : 2'd2;
                        mul_en    <= 1'b1;
                        mul_a     <= bus.src1[HALF-1:0];
                        mul_b     <= bus.src2[HALF-1:0];
                        bus.ready <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (bus.abort) begin
                        // Dropping prod_v discards the product still inside the cell.
                        prod_v    <= 1'b0;
                        mul_en    <= 1'b0;
                        mul_a     <= '0;
                        mul_b     <= '0;
                        bus.ready <= 1'b1;
                        state     <= S_IDLE;
                    end else if (k == last_k) begin
                        mul_en <= 1'b0;
                        mul_a  <= '0;
                        mul_b  <= '0;
                        state  <= S_DRAIN;
                    end else begin
                        k     <= next_k;
                        mul_a <= pick(a_q, next_k[1]);
                        mul_b <= pick(b_q, next_k[0]);
                    end
                end

                S_DRAIN: begin
                    if (bus.abort) begin
                        bus.ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        // The last product is arriving now, so the result uses the post-add sum.
                        bus.result <= op_hi_q ? acc_sum[ACC_W-1:WIDTH] : acc_sum[WIDTH-1:0];
                        bus.done   <= 1'b1;
                        state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    bus.ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    bus.ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
